// File: rtl/conv_accumulator.sv
`default_nettype none
// ============================================================================
// conv_accumulator : registered adder tree over KERNEL_SIZE^2 signed products,
//                    then accumulation across NUM_CHANNELS vectors per result
// Revision: 1.0
// ============================================================================
module conv_accumulator #(
    parameter int DATA_WIDTH   = 32,
    parameter int KERNEL_SIZE  = 3,
    parameter int NUM_CHANNELS = 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] products,
    input  logic                                        clear,
    output logic                                        out_valid,
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic                                        busy
);

    localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int LEVELS = (N == 1) ? 0 : $clog2(N);
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int VLD_W  = (LEVELS > 0) ? LEVELS : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CHANNELS - 1);

    // Number of entries present at a given tree level (odd tails pass through).
    function automatic int level_count(input int leaves, input int lvl);
        int c;
        c = leaves;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

    logic [DATA_WIDTH-1:0] w_tree_sum;
    logic                  w_tree_vld;
    logic [VLD_W-1:0]      w_vld_bits;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [CH_W-1:0]       r_ch;

    generate
        for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
            localparam int IN_CNT  = level_count(N, l);
            localparam int OUT_CNT = level_count(N, l + 1);

            logic [DATA_WIDTH-1:0] w_in   [IN_CNT];
            logic [DATA_WIDTH-1:0] w_pair [OUT_CNT];
            logic [DATA_WIDTH-1:0] r_node [OUT_CNT];
            logic                  w_vld_in;
            logic                  r_vld;

            if (l == 0) begin : g_src
                for (genvar i = 0; i < IN_CNT; i++) begin : g_tap
                    assign w_in[i] = products[i*DATA_WIDTH +: DATA_WIDTH];
                end
                assign w_vld_in = in_valid;
            end else begin : g_src
                for (genvar i = 0; i < IN_CNT; i++) begin : g_tap
                    assign w_in[i] = g_lvl[l-1].r_node[i];
                end
                assign w_vld_in = g_lvl[l-1].r_vld;
            end

            for (genvar k = 0; k < OUT_CNT; k++) begin : g_node
                if (2*k + 1 < IN_CNT) begin : g_add
                    assign w_pair[k] = w_in[2*k] + w_in[2*k+1];
                end else begin : g_pass
                    assign w_pair[k] = w_in[2*k];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    for (int k = 0; k < OUT_CNT; k++) r_node[k] <= '0;
                end else begin
                    r_vld <= w_vld_in & ~clear;
                    for (int k = 0; k < OUT_CNT; k++) r_node[k] <= w_pair[k];
                end
            end

            assign w_vld_bits[l] = r_vld;
        end

        if (LEVELS == 0) begin : g_fin
            assign w_tree_sum = products[DATA_WIDTH-1:0];
            assign w_tree_vld = in_valid;
            assign w_vld_bits = '0;
        end else begin : g_fin
            assign w_tree_sum = g_lvl[LEVELS-1].r_node[0];
            assign w_tree_vld = g_lvl[LEVELS-1].r_vld;
        end
    endgenerate

    // First channel of a group starts fresh; later channels add to the partial sum.
    assign w_sum = ((r_ch == '0) ? '0 : r_acc) + w_tree_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch      <= '0;
            r_acc     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            r_ch      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (w_tree_vld) begin
                r_acc <= w_sum;
                if (r_ch == CH_LAST) begin
                    out_data  <= w_sum;
                    out_valid <= 1'b1;
                    r_ch      <= '0;
                end else begin
                    r_ch <= r_ch + CH_W'(1);
                end
            end
        end
    end

    assign busy = (|w_vld_bits) | (r_ch != '0);

endmodule
`default_nettype wire

// File: doc/conv_accumulator.md
# conv_accumulator

Pipelined reduction stage that sits directly downstream of the per-tap multiplier array in the convolver. It consumes the packed vector of KERNEL_SIZE² signed products and sums it with a registered adder tree. It then accumulates the per-window sums across NUM_CHANNELS consecutive input channels and emits one DATA_WIDTH convolution result per completed channel group. It streams at one product vector per clock with no backpressure.

## Interface
- DATA_WIDTH, 32, width of each product and of the result (signed two's complement)
- KERNEL_SIZE, 3, kernel edge; leaf count N = KERNEL_SIZE²
- NUM_CHANNELS, 1, product vectors summed per output (≥1)

- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  products valid this cycle
- products  input  N*DATA_WIDTH  packed products, tap i at [i*DATA_WIDTH +: DATA_WIDTH]
- clear  input  1  synchronous abort of in-flight and partial work
- out_valid  output  1  one-cycle pulse: out_data holds a new result
- out_data  output  DATA_WIDTH  signed accumulated result, held between pulses
- busy  output  1  high while any pipeline valid bit is set or the channel count is nonzero

## Operation
- The adder tree has L = clog2(N) registered levels, with L=0 when N=1. For N=9, L=4.
  - Each level pairs adjacent entries in index order: entry 2k with entry 2k+1.
  - An odd trailing entry passes through that level's register unchanged.
- A valid bit travels alongside each tree level.
- All arithmetic is signed and modulo 2^DATA_WIDTH (wrap, no saturation), which matches the truncated products upstream. No width growth.
- The channel counter `ch` runs over 0..NUM_CHANNELS-1. It advances only when the valid bit of the final tree level is high.
  - If ch==0: acc ← tree_sum.
  - Otherwise: acc ← acc + tree_sum.
  - If ch==NUM_CHANNELS-1:
    - out_data ← value just computed, i.e. (ch==0 ? 0 : acc) + tree_sum.
    - out_valid ← 1 on the next cycle.
    - ch ← 0.
  - Otherwise ch ← ch+1 and out_valid ← 0.
- NUM_CHANNELS=1: every valid tree output produces an output.
- Gaps in in_valid are allowed anywhere, including inside a channel group. The partial accumulation is held, not discarded.
- clear (synchronous):
  - Zeroes all pipeline valid bits and ch.
  - out_valid is 0 on the next cycle.
  - acc and out_data keep their values.
  - If clear and in_valid are both high in the same cycle, clear wins and that input is dropped.
  - If the final tree stage is valid in the same cycle as clear, it is discarded.
- Reset (rst_n low, any time, including mid-group):
  - All data registers, valid bits, ch, out_valid, out_data, acc → 0 immediately.
  - busy → 0.
  - Operation resumes on the first rising edge after deassertion.

## Timing
- Throughput: one product vector per cycle, sustained indefinitely.
- Latency: a vector accepted at edge t reaches the final tree level at edge t+L. A result completed by that vector has out_valid high in the cycle following edge t+L+1.
  - N=9: out_valid is high 5 cycles after the in_valid cycle.
  - N=1: 1 cycle.
- out_valid is never high for two cycles from one group. Back-to-back groups with NUM_CHANNELS=1 give out_valid high on consecutive cycles.
- busy is combinational from registers: it is the OR of the tree valid bits and (ch≠0).
- Reset values: out_valid=0, out_data=0, busy=0.

## Test plan
- N=9, NUM_CHANNELS=1, all taps = 1, single in_valid pulse → out_valid pulse 5 cycles later with out_data = 9. busy is high for 4 cycles, then low. out_data holds 9 afterwards.
- Signed mix: taps {-3,2,5,-7,0,1,1,-1,4} → out_data = 2. Then all taps = 0x7FFFFFFF → out_data = 0x7FFFFFF7 (wrap).
- NUM_CHANNELS=3, three back-to-back vectors with all taps 1, 2, 3 → single out_valid with out_data = 54, 5 cycles after the third vector. An immediately following group of all-ones ×3 gives 27, with no carry-over.
- NUM_CHANNELS=3, vectors with idle gaps (valid on cycles 0, 4, 9; all taps 1) → one result = 27, 5 cycles after cycle 9.
- NUM_CHANNELS=3, clear after two vectors, with clear and in_valid both high for a third vector → no out_valid, busy drops next cycle. The following three all-ones vectors give 27.
- Random streams of 1000 vectors with random in_valid, compared against a reference model; rst_n asserted mid-group → outputs zero immediately and the first post-reset group is correct.
